// File: rtl/npu_conv_sched.sv
// -----------------------------------------------------------------------------
// NpuConvSched (module npu_conv_sched)
//
// Purpose:
//   Runs one convolution pass between the image/conv RAMs and npu_top.
//   For each filter group it first streams the KERNEL*KERNEL filter weights out
//   of the conv RAM (en_config phase). It then slides a KERNELxKERNEL window
//   over the IMG_W x IMG_W image, streaming each window's pixels (en_fsm phase),
//   and waits for one NPU result per window. This repeats for NUM_FILTERS groups.
//   Both RAMs have one cycle of read latency. The beat strobes are therefore the
//   address-issue strobes delayed by one cycle, so each strobe lines up with its
//   read data.
//
// Ports:
//   i_clk              system clock
//   i_reset            synchronous, active-low reset
//   i_start            1-cycle pulse, begins a pass (only honoured in IDLE)
//   i_abort            synchronous abort, honoured in any state
//   i_npu_done         1-cycle pulse, NPU result for the current window is valid
//   o_image_ram_addr   image RAM read address
//   o_conv_ram_addr    conv RAM read address
//   o_en_config        weight beat valid at the NPU input
//   o_en_fsm           pixel beat valid at the NPU input
//   o_out_valid        1-cycle pulse, capture D_OUT at o_out_addr
//   o_out_addr         result index (filter-major, then row-major)
//   o_busy             high in every state except IDLE
//   o_done             1-cycle pulse when all filters are complete
//   o_err              sticky error; cleared by reset or by an accepted start
//
// Optional build macro:
//   NPU_SCHED_TIMEOUT_EN  adds a WAIT watchdog. If TIMEOUT cycles pass in WAIT
//                         without i_npu_done, the block sets o_err and drops
//                         back to IDLE without a done pulse.
// -----------------------------------------------------------------------------
module npu_conv_sched #(
  parameter int IMG_W       = 28,
  parameter int KERNEL      = 3,
  parameter int NUM_FILTERS = 4,
  parameter int IMG_ADDR_W  = 10,
  parameter int CONV_ADDR_W = 15,
  parameter int OUT_ADDR_W  = 12,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_npu_done,
  output logic [IMG_ADDR_W-1:0]  o_image_ram_addr,
  output logic [CONV_ADDR_W-1:0] o_conv_ram_addr,
  output logic                   o_en_config,
  output logic                   o_en_fsm,
  output logic                   o_out_valid,
  output logic [OUT_ADDR_W-1:0]  o_out_addr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int KK = KERNEL * KERNEL;
  localparam int KW = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int PW = ((IMG_W - KERNEL + 1) > 1) ? $clog2(IMG_W - KERNEL + 1) : 1;
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [KW-1:0]          LastTap      = KW'(KERNEL - 1);
  localparam logic [PW-1:0]          LastPos      = PW'(IMG_W - KERNEL);
  localparam logic [FW-1:0]          LastFilter   = FW'(NUM_FILTERS - 1);
  localparam logic [IMG_ADDR_W-1:0]  RowStride    = IMG_ADDR_W'(IMG_W);
  localparam logic [CONV_ADDR_W-1:0] FilterStride = CONV_ADDR_W'(KK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_FEED,
    S_WAIT,
    S_DONE
  } stateT;

  stateT r_state;
  stateT w_nextState;

  // Tap position inside the window. It is shared by CONFIG and FEED because
  // both phases run exactly KERNEL*KERNEL beats.
  logic [KW-1:0]          r_tapRow;
  logic [KW-1:0]          r_tapCol;
  // Window origin, plus running image addresses that replace multipliers.
  logic [PW-1:0]          r_winRow;
  logic [PW-1:0]          r_winCol;
  logic [IMG_ADDR_W-1:0]  r_rowStart;
  logic [IMG_ADDR_W-1:0]  r_winBase;
  logic [IMG_ADDR_W-1:0]  r_rowPtr;
  logic [FW-1:0]          r_filter;
  logic [CONV_ADDR_W-1:0] r_filterBase;
  logic [OUT_ADDR_W-1:0]  r_outIdx;

  logic [IMG_ADDR_W-1:0]  r_imgAddr;
  logic [CONV_ADDR_W-1:0] r_convAddr;
  logic [OUT_ADDR_W-1:0]  r_outAddr;
  logic                   r_cfgStrobe;
  logic                   r_fsmStrobe;
  logic                   r_outValid;
  logic                   r_err;

  logic w_lastTap;
  logic w_lastWindow;
  logic w_lastFilter;
  logic w_startAccept;
  logic w_stray;
  logic w_timeout;
  logic w_cfgIssue;
  logic w_feedIssue;
  logic w_busy;
  logic w_done;

  assign w_lastTap     = (r_tapRow == LastTap) && (r_tapCol == LastTap);
  assign w_lastWindow  = (r_winRow == LastPos) && (r_winCol == LastPos);
  assign w_lastFilter  = (r_filter == LastFilter);
  assign w_startAccept = (r_state == S_IDLE) && i_start && !i_abort;
  // npu_done counts only in WAIT. This also covers the cycle of the last FEED
  // beat, because the state has not reached WAIT yet.
  assign w_stray       = i_npu_done && (r_state != S_WAIT);

`ifdef NPU_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LastWait = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_waitCnt;

  // Watchdog counter. It is held at zero outside WAIT, so every WAIT entry
  // starts counting from zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_abort || (r_state != S_WAIT)) begin
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= r_waitCnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !i_npu_done && (r_waitCnt == LastWait);
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT != 0);
  assign w_timeout       = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Abort overrides everything else, including start and
  // npu_done in the same cycle.
  always_comb begin
    w_nextState = r_state;
    if (i_abort) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start) w_nextState = S_CONFIG;
        S_CONFIG: if (w_lastTap) w_nextState = S_FEED;
        S_FEED:   if (w_lastTap) w_nextState = S_WAIT;
        S_WAIT: begin
          if (i_npu_done) begin
            if (!w_lastWindow)     w_nextState = S_FEED;
            else if (w_lastFilter) w_nextState = S_DONE;
            else                   w_nextState = S_CONFIG;
          end else if (w_timeout) begin
            w_nextState = S_IDLE;
          end
        end
        S_DONE:   w_nextState = S_IDLE;
        default:  w_nextState = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state. Address issue happens in CONFIG and FEED,
  // and each issue strobe reaches the NPU one cycle later through a register.
  always_comb begin
    w_cfgIssue  = 1'b0;
    w_feedIssue = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:   w_busy      = 1'b0;
      S_CONFIG: w_cfgIssue  = 1'b1;
      S_FEED:   w_feedIssue = 1'b1;
      S_DONE:   w_done      = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: window walk, address generation, result indexing and strobes.
  // Abort clears everything just like reset does. This also drops the strobe
  // for an address that was issued in the abort cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_abort) begin
      r_tapRow     <= '0;
      r_tapCol     <= '0;
      r_winRow     <= '0;
      r_winCol     <= '0;
      r_rowStart   <= '0;
      r_winBase    <= '0;
      r_rowPtr     <= '0;
      r_filter     <= '0;
      r_filterBase <= '0;
      r_outIdx     <= '0;
      r_imgAddr    <= '0;
      r_convAddr   <= '0;
      r_outAddr    <= '0;
      r_cfgStrobe  <= 1'b0;
      r_fsmStrobe  <= 1'b0;
      r_outValid   <= 1'b0;
    end else begin
      r_cfgStrobe <= w_cfgIssue;
      r_fsmStrobe <= w_feedIssue;
      r_outValid  <= 1'b0;

      // The tap counters step through the window row by row in both
      // streaming phases, and wrap to zero on the last tap.
      if (w_cfgIssue || w_feedIssue) begin
        if (r_tapCol == LastTap) begin
          r_tapCol <= '0;
          r_tapRow <= (r_tapRow == LastTap) ? '0 : r_tapRow + KW'(1);
        end else begin
          r_tapCol <= r_tapCol + KW'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_tapRow     <= '0;
            r_tapCol     <= '0;
            r_winRow     <= '0;
            r_winCol     <= '0;
            r_rowStart   <= '0;
            r_winBase    <= '0;
            r_filter     <= '0;
            r_filterBase <= '0;
            r_outIdx     <= '0;
            r_convAddr   <= '0;
          end
        end

        S_CONFIG: begin
          if (!w_lastTap) begin
            r_convAddr <= r_convAddr + CONV_ADDR_W'(1);
          end else begin
            r_imgAddr <= r_winBase;
            r_rowPtr  <= r_winBase;
          end
        end

        // Within a row the pixel address just increments. At the end of a
        // row it jumps to the next image row, one stride past the row pointer.
        S_FEED: begin
          if (!w_lastTap) begin
            if (r_tapCol == LastTap) begin
              r_imgAddr <= r_rowPtr + RowStride;
              r_rowPtr  <= r_rowPtr + RowStride;
            end else begin
              r_imgAddr <= r_imgAddr + IMG_ADDR_W'(1);
            end
          end
        end

        S_WAIT: begin
          if (i_npu_done) begin
            r_outValid <= 1'b1;
            r_outAddr  <= r_outIdx;
            r_outIdx   <= r_outIdx + OUT_ADDR_W'(1);
            if (r_winCol != LastPos) begin
              r_winCol  <= r_winCol + PW'(1);
              r_winBase <= r_winBase + IMG_ADDR_W'(1);
              r_imgAddr <= r_winBase + IMG_ADDR_W'(1);
              r_rowPtr  <= r_winBase + IMG_ADDR_W'(1);
            end else if (r_winRow != LastPos) begin
              r_winCol   <= '0;
              r_winRow   <= r_winRow + PW'(1);
              r_rowStart <= r_rowStart + RowStride;
              r_winBase  <= r_rowStart + RowStride;
              r_imgAddr  <= r_rowStart + RowStride;
              r_rowPtr   <= r_rowStart + RowStride;
            end else begin
              r_winCol   <= '0;
              r_winRow   <= '0;
              r_rowStart <= '0;
              r_winBase  <= '0;
              if (w_lastFilter) begin
                r_filter <= '0;
              end else begin
                r_filter     <= r_filter + FW'(1);
                r_filterBase <= r_filterBase + FilterStride;
                r_convAddr   <= r_filterBase + FilterStride;
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

  // Sticky error flag. It is set by a stray npu_done or by a watchdog expiry,
  // and cleared by an accepted start. Abort leaves it untouched.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_err <= 1'b0;
    end else if (!i_abort) begin
      if (w_stray || w_timeout) begin
        r_err <= 1'b1;
      end else if (w_startAccept) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_image_ram_addr = r_imgAddr;
  assign o_conv_ram_addr  = r_convAddr;
  assign o_en_config      = r_cfgStrobe;
  assign o_en_fsm         = r_fsmStrobe;
  assign o_out_valid      = r_outValid;
  assign o_out_addr       = r_outAddr;
  assign o_busy           = w_busy;
  assign o_done           = w_done;
  assign o_err            = r_err;

endmodule

// File: tb/tb_npu_conv_sched.sv
// -----------------------------------------------------------------------------
// tb_npu_conv_sched
//
// Scoreboard bench for npu_conv_sched, built with IMG_W=4, KERNEL=2 and
// NUM_FILTERS=2.
//   - The main process drives start/abort and pushes the expected weight
//     addresses, pixel addresses and result indices into queues.
//   - A monitor pops one entry per en_config, en_fsm or out_valid beat.
//   - A responder acknowledges every completed window with npu_done.
// The timeout scenario runs only when NPU_SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_npu_conv_sched;

  localparam int ImgW = 4;
  localparam int Kern = 2;
  localparam int NumF = 2;
  localparam int Kk   = Kern * Kern;
  localparam int Pos  = ImgW - Kern + 1;
  localparam int Tmo  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        respDone;
  logic        extraDone;
  logic        respEn;
  logic        npuDone;
  logic [9:0]  imageRamAddr;
  logic [14:0] convRamAddr;
  logic        enConfig;
  logic        enFsm;
  logic        outValid;
  logic [11:0] outAddr;
  logic        busy;
  logic        done;
  logic        err;

  int errors    = 0;
  int checks    = 0;
  int doneCount = 0;

  int expCfg[$];
  int expPix[$];
  int expOut[$];

  // Pixel addresses of the first window (r=0, c=0), worked out by hand.
  int firstWin[4] = '{0, 1, 4, 5};

  assign npuDone = respDone | extraDone;

  always #5 clk = ~clk;

  npu_conv_sched #(
    .IMG_W(ImgW), .KERNEL(Kern), .NUM_FILTERS(NumF),
    .IMG_ADDR_W(10), .CONV_ADDR_W(15), .OUT_ADDR_W(12), .TIMEOUT(Tmo)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_start(start),
    .i_abort(abort),
    .i_npu_done(npuDone),
    .o_image_ram_addr(imageRamAddr),
    .o_conv_ram_addr(convRamAddr),
    .o_en_config(enConfig),
    .o_en_fsm(enFsm),
    .o_out_valid(outValid),
    .o_out_addr(outAddr),
    .o_busy(busy),
    .o_done(done),
    .o_err(err)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: unexpected beat carrying %0d, expected no beat", name, actual);
  endtask

  // Drives start/abort for one cycle. Call it at a negedge; it returns at the
  // following negedge.
  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Expected traffic for a complete pass, built from the closed-form address
  // (r+i)*W + c + j.
  task automatic pushFullPass();
    int idx;
    idx = 0;
    for (int f = 0; f < NumF; f++) begin
      for (int k = 0; k < Kk; k++) expCfg.push_back(f * Kk + k);
      for (int r = 0; r < Pos; r++) begin
        for (int c = 0; c < Pos; c++) begin
          for (int i = 0; i < Kern; i++) begin
            for (int j = 0; j < Kern; j++) expPix.push_back((r + i) * ImgW + c + j);
          end
          expOut.push_back(idx);
          idx++;
        end
      end
    end
  endtask

  // Expected traffic for filter 0's weights and the first window only.
  task automatic pushFirstWindow(input bit withResult);
    for (int k = 0; k < Kk; k++) expCfg.push_back(k);
    for (int k = 0; k < 4; k++) expPix.push_back(firstWin[k]);
    if (withResult) expOut.push_back(0);
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_cfgLeft"}, expCfg.size(), 0);
    checkOutput({tag, "_pixLeft"}, expPix.size(), 0);
    checkOutput({tag, "_outLeft"}, expOut.size(), 0);
  endtask

  task automatic waitForDone(input int maxCycles);
    int n;
    n = 0;
    while (!done && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      reportUnexpected("doneTimeout", n);
    end else begin
      checkOutput("busyInDone", int'(busy), 1);
      @(negedge clk);
      checkOutput("busyAfterDone", int'(busy), 0);
      checkOutput("donePulseWidth", int'(done), 0);
      checkOutput("errAfterPass", int'(err), 0);
    end
  endtask

  task automatic waitForOutValid(input int maxCycles);
    int n;
    n = 0;
    while (!outValid && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (!outValid) reportUnexpected("outValidTimeout", n);
  endtask

  // Returns at the negedge where the n-th en_fsm beat of this wait is seen.
  task automatic waitForPixelBeats(input int count, input int maxCycles);
    int seen;
    int n;
    seen = 0;
    n = 0;
    while (n < maxCycles) begin
      if (enFsm) seen++;
      if (seen == count) break;
      @(negedge clk);
      n++;
    end
    if (seen != count) reportUnexpected("pixelBeatTimeout", seen);
  endtask

  // Monitor: compares each beat and each result against the scoreboard. A
  // beat's address is the one that was on the bus one cycle earlier.
  initial begin
    int prevConv;
    int prevImg;
    int e;
    prevConv = 0;
    prevImg  = 0;
    forever begin
      @(negedge clk);
      if (enConfig) begin
        if (expCfg.size() == 0) reportUnexpected("cfgBeat", prevConv);
        else begin
          e = expCfg.pop_front();
          checkOutput("cfgAddr", prevConv, e);
        end
      end
      if (enFsm) begin
        if (expPix.size() == 0) reportUnexpected("pixBeat", prevImg);
        else begin
          e = expPix.pop_front();
          checkOutput("pixAddr", prevImg, e);
        end
      end
      if (outValid) begin
        if (expOut.size() == 0) reportUnexpected("outBeat", int'(outAddr));
        else begin
          e = expOut.pop_front();
          checkOutput("outAddr", int'(outAddr), e);
        end
      end
      if (done) doneCount++;
      prevConv = int'(convRamAddr);
      prevImg  = int'(imageRamAddr);
    end
  end

  // Responder: after the last pixel beat of each window, the NPU answers with
  // a one-cycle npu_done.
  initial begin
    int beats;
    beats    = 0;
    respDone = 1'b0;
    forever begin
      @(negedge clk);
      respDone = 1'b0;
      if (enFsm) begin
        beats++;
        if (beats == Kk) begin
          beats = 0;
          if (respEn) respDone = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 ns, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b1;
    abort     = 1'b0;
    extraDone = 1'b0;
    respEn    = 1'b0;

    // Reset held low for three cycles with start asserted throughout.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstEnConfig", int'(enConfig), 0);
    checkOutput("rstEnFsm", int'(enFsm), 0);
    checkOutput("rstOutValid", int'(outValid), 0);
    checkOutput("rstErr", int'(err), 0);
    checkOutput("rstOutAddr", int'(outAddr), 0);
    checkOutput("rstConvAddr", int'(convRamAddr), 0);
    checkOutput("rstImgAddr", int'(imageRamAddr), 0);
    @(negedge clk);
    checkOutput("idleStaysIdle", int'(busy), 0);

    // Full pass. Weight-phase timing is checked cycle by cycle.
    $display("[TB] full pass with cycle-exact config checks");
    pushFullPass();
    respEn = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc <= 4) checkOutput("cfgIssueAddr", int'(convRamAddr), cyc - 1);
      checkOutput("enConfigTiming", int'(enConfig), (cyc >= 2 && cyc <= 5) ? 1 : 0);
      @(negedge clk);
    end
    checkOutput("busyDuringPass", int'(busy), 1);
    waitForDone(3000);
    checkQueuesEmpty("pass1");
    checkOutput("pass1DonePulses", doneCount, 1);

    // Abort while the second window's pixels are streaming.
    $display("[TB] abort during second window");
    pushFirstWindow(1'b1);
    applyStimulus(1'b1, 1'b0);
    waitForOutValid(500);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortEnFsm", int'(enFsm), 0);
    checkOutput("abortOutValid", int'(outValid), 0);
    repeat (10) @(negedge clk);
    checkOutput("abortNoDone", doneCount, 1);
    checkQueuesEmpty("abort");

    // A restarted full pass, with an extra start mid-pass that must be ignored.
    $display("[TB] restart after abort, start while busy");
    pushFullPass();
    applyStimulus(1'b1, 1'b0);
    checkOutput("restartConvAddr", int'(convRamAddr), 0);
    repeat (20) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("busyAfterIgnoredStart", int'(busy), 1);
    waitForDone(3000);
    checkQueuesEmpty("pass2");
    checkOutput("pass2DonePulses", doneCount, 2);

    // A stray npu_done in IDLE sets err.
    extraDone = 1'b1;
    @(negedge clk);
    extraDone = 1'b0;
    checkOutput("errStrayIdle", int'(err), 1);
    checkOutput("busyStrayIdle", int'(busy), 0);

    // npu_done on the cycle of the last FEED beat is a stray.
    $display("[TB] npu_done on last feed beat");
    pushFirstWindow(1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("errClearedByStart", int'(err), 0);
    waitForPixelBeats(3, 200);
    extraDone = 1'b1;
    @(negedge clk);
    extraDone = 1'b0;
    checkOutput("errDoneOnLastBeat", int'(err), 1);
    waitForOutValid(500);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("errSurvivesAbort", int'(err), 1);
    repeat (5) @(negedge clk);
    checkQueuesEmpty("lastBeat");

`ifdef NPU_SCHED_TIMEOUT_EN
    // No NPU response: the watchdog fires 16 cycles into WAIT.
    $display("[TB] wait watchdog");
    respEn = 1'b0;
    pushFirstWindow(1'b0);
    applyStimulus(1'b1, 1'b0);
    waitForPixelBeats(4, 200);
    repeat (15) @(negedge clk);
    checkOutput("busyAtWait16", int'(busy), 1);
    checkOutput("errAtWait16", int'(err), 0);
    @(negedge clk);
    checkOutput("busyAfterTimeout", int'(busy), 0);
    checkOutput("errAfterTimeout", int'(err), 1);
    checkOutput("timeoutNoDone", doneCount, 2);
    checkQueuesEmpty("timeout");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
